// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and default timing constants for the key conditioner.
package key_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} key_state_t;
    localparam int KEY_CLK_DIV    = 50000;
    localparam int KEY_DEB_TICKS  = 20;
    localparam int KEY_REP_DELAY  = 500;
    localparam int KEY_REP_PERIOD = 100;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider, one-cycle tick every CLK_DIV clocks.
module tick_gen
    import key_pkg::*;
#(
    parameter int CLK_DIV = KEY_CLK_DIV
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = (cnt_q == W'(CLK_DIV - 1));
    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge CLK or posedge RST)
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce an active-low key into a press pulse and pressed level.
// Define KEY_REPEAT_EN to add auto-repeat pulses while the key stays held.
module key_debounce
    import key_pkg::*;
#(
    parameter int CLK_DIV    = KEY_CLK_DIV,
    parameter int DEB_TICKS  = KEY_DEB_TICKS,
    parameter int REP_DELAY  = KEY_REP_DELAY,
    parameter int REP_PERIOD = KEY_REP_PERIOD
) (
    input  logic CLK,
    input  logic RST,
    input  logic nBIN,
    output logic BOUT,
    output logic LEVEL
);
    localparam int MW = $clog2(DEB_TICKS + 1);
    key_state_t    state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [MW-1:0] match_q, match_d, match_inc;
    logic          level_q, level_d, bout_q, bout_d;
    logic          tick, raw, done, rep_fire;

    if (CLK_DIV < 2 || DEB_TICKS < 2 || REP_DELAY < 1 || REP_PERIOD < 1)
        $error("key_debounce: timing parameters out of range");

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.CLK(CLK), .RST(RST), .tick(tick));

    assign raw       = ~sync_q[1];
    assign match_inc = (match_q == MW'(DEB_TICKS)) ? match_q : match_q + 1'b1;
    assign done      = (match_inc == MW'(DEB_TICKS));

    always_comb begin
        sync_d  = {sync_q[0], nBIN};
        state_d = state_q;
        match_d = match_q;
        level_d = level_q;
        bout_d  = rep_fire;
        if (tick) begin
            case (state_q)
                IDLE: if (raw) begin
                    state_d = PRESS_CHK;
                    match_d = MW'(1);
                end
                PRESS_CHK: begin
                    state_d = raw ? (done ? PRESSED : PRESS_CHK) : IDLE;
                    match_d = (raw && !done) ? match_inc : '0;
                    level_d = raw && done;
                    bout_d  = raw && done;
                end
                PRESSED: if (!raw) begin
                    state_d = REL_CHK;
                    match_d = MW'(1);
                end
                REL_CHK: begin
                    state_d = !raw ? (done ? IDLE : REL_CHK) : PRESSED;
                    match_d = (!raw && !done) ? match_inc : '0;
                    level_d = raw || !done;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            match_q <= '0;
            level_q <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            match_q <= match_d;
            level_q <= level_d;
            bout_q  <= bout_d;
        end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REP_DELAY + REP_PERIOD + 1);
    logic [RW-1:0] rep_q, rep_d, rep_inc;
    // Counter survives REL_CHK bounces; it only restarts once the key is back in IDLE.
    always_comb begin
        rep_inc  = rep_q + 1'b1;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (tick && state_q == PRESSED && raw) begin
            rep_fire = (rep_inc == RW'(REP_DELAY)) || (rep_inc == RW'(REP_DELAY + REP_PERIOD));
            rep_d    = (rep_inc == RW'(REP_DELAY + REP_PERIOD)) ? RW'(REP_DELAY) : rep_inc;
        end
        if (state_q == IDLE)
            rep_d = '0;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) rep_q <= '0;
        else     rep_q <= rep_d;
`else
    assign rep_fire = 1'b0;
`endif

    assign BOUT  = bout_q;
    assign LEVEL = level_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; expected BOUT cycle windows are queued as the key is driven.
module tb_key_debounce;
    localparam int CLK_DIV = 4, DEB_TICKS = 3, REP_DELAY = 5, REP_PERIOD = 2;

    typedef struct {int lo; int hi;} win_t;

    logic clk = 1'b0, rst = 1'b1, n_bin = 1'b1;
    logic bout, level, prev_bout = 1'b0;
    int   cyc = 0, rst_cyc = 0, n_chk = 0, n_err = 0, c;
    win_t sb[$];

    key_debounce #(
        .CLK_DIV(CLK_DIV), .DEB_TICKS(DEB_TICKS), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
    ) dut (.CLK(clk), .RST(rst), .nBIN(n_bin), .BOUT(bout), .LEVEL(level));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // First tick edge that samples a key driven low just after edge c; ticks fall on rst_cyc + k*CLK_DIV.
    function automatic int first_tick(input int fall);
        int k = fall + 3;
        while ((k - rst_cyc) % CLK_DIV != 0) k++;
        return k;
    endfunction

    task automatic expect_press(input int fall, input int hold, input bit exact);
        int a = first_tick(fall) + (DEB_TICKS - 1) * CLK_DIV;
        sb.push_back('{exact ? a : fall + 3, a});
`ifdef KEY_REPEAT_EN
        for (int e = a + REP_DELAY * CLK_DIV; e <= fall + hold + 2; e += REP_PERIOD * CLK_DIV)
            sb.push_back('{e, e});
`endif
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (sb.size() != 0 && cyc > sb[0].hi) begin
            check("bout_missing", 0, sb[0].hi);
            void'(sb.pop_front());
        end
        if (bout) begin
            check("bout_pair", prev_bout, 0);
            if (sb.size() == 0)
                check("bout_spurious", 1, 0);
            else begin
                check("bout_cyc", cyc, cyc < sb[0].lo ? sb[0].lo : cyc > sb[0].hi ? sb[0].hi : cyc);
                void'(sb.pop_front());
            end
        end
        prev_bout <= bout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached, bench did not finish", cyc);
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_bout", bout, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        rst_cyc = cyc;
        step(5);
        n_bin = 1'b0;
        c = cyc;
        expect_press(c, 40, 1'b1);
        step(40);
        check("clean_level", level, 1);
        n_bin = 1'b1;
        step(40);
        check("clean_release", level, 0);
        for (int i = 0; i < 10; i++) begin
            n_bin = ~n_bin;
            step(3);
        end
        check("bounce_level", level, 0);
        n_bin = 1'b0;
        c = cyc;
        expect_press(c, 16, 1'b0);
        step(16);
        check("bounce_accept", level, 1);
        n_bin = 1'b1;
        step(40);
        check("bounce_release", level, 0);
        n_bin = 1'b0;
        step(6);
        n_bin = 1'b1;
        step(20);
        check("glitch_level", level, 0);
        n_bin = 1'b0;
        c = cyc;
        expect_press(c, 16, 1'b1);
        step(16);
        n_bin = 1'b1;
        step(4);
        n_bin = 1'b0;
        step(8);
        check("relbounce_level", level, 1);
        n_bin = 1'b1;
        step(40);
        check("relbounce_release", level, 0);
        n_bin = 1'b0;
        step(8);
        rst = 1'b1;
        #1;
        check("rst_chk_bout", bout, 0);
        check("rst_chk_level", level, 0);
        step(2);
        rst = 1'b0;
        rst_cyc = cyc;
        expect_press(cyc, 16, 1'b1);
        step(16);
        check("rst_rearm_level", level, 1);
        rst = 1'b1;
        #1;
        check("rst_held_bout", bout, 0);
        check("rst_held_level", level, 0);
        step(2);
        rst = 1'b0;
        rst_cyc = cyc;
        expect_press(cyc, 60, 1'b1);
        step(60);
        check("hold_level", level, 1);
        n_bin = 1'b1;
        step(40);
        check("hold_release", level, 0);
        check("pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
